// File: rtl/move_sequencer_if.sv
// Bundle between the move sequencer, the command logic feeding it and the stepper drivers.
// The master modport is the sequencer's view; slave is the environment's view.
interface move_sequencer_if #(
   parameter int NUM_MOTORS = 6
);
   // Move requests use valid/ready: a move transfers on a rising edge where
   // move_valid & move_ready are both high; move_* fields are sampled only then.
   logic                  move_valid;
   logic                  move_ready;
   logic [2:0]            move_motor;
   logic                  move_dir;
   logic                  move_half;
   logic                  clear_error;
   logic [NUM_MOTORS-1:0] start;
   logic [7:0]            steps;
   logic [NUM_MOTORS-1:0] dir;
   logic [NUM_MOTORS-1:0] done;
   logic                  busy;
   logic                  error;
   logic [7:0]            moves_done;

   modport master (
      input  move_valid, move_motor, move_dir, move_half, clear_error, done,
      output move_ready, start, steps, dir, busy, error, moves_done
   );

   modport slave (
      output move_valid, move_motor, move_dir, move_half, clear_error, done,
      input  move_ready, start, steps, dir, busy, error, moves_done
   );
endinterface

// File: rtl/move_sequencer.sv
// Queues cube-face moves and issues them one at a time to the stepper drivers,
// waiting for each driver's done and enforcing a settle gap between moves.
module move_sequencer #(
   parameter int NUM_MOTORS     = 6,
   parameter int QUARTER_STEPS  = 50,
   parameter int FIFO_DEPTH     = 4,
   parameter int GAP_CYCLES     = 1000,
   parameter int TIMEOUT_CYCLES = 1 << 24
) (
   input  logic             clock,
   input  logic             reset_n,
   move_sequencer_if.master bus,
   output logic [2:0]       fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_ARM   = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [AW:0]   DEPTH_CNT    = (AW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYCLES - 1);
   localparam logic [7:0]    STEPS_QUARTER = 8'(QUARTER_STEPS);
   localparam logic [7:0]    STEPS_HALF    = 8'(2 * QUARTER_STEPS);

   state_t state, state_next;

   logic [4:0]            fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [AW:0]           count;
   logic                  empty, full, push, pop;

   logic [2:0]            head_motor;
   logic                  head_dir, head_half, head_bad;
   logic [NUM_MOTORS-1:0] head_mask;

   logic [NUM_MOTORS-1:0] cur_mask;
   logic [TW-1:0]         timer;
   logic [GW-1:0]         gap_cnt;
   logic                  done_sel;
   logic                  load_move, complete, err_set;

   logic [7:0]            steps_q;
   logic [NUM_MOTORS-1:0] dir_q;
   logic                  error_q;
   logic [7:0]            moves_done_q;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_CNT);
   assign push  = bus.move_valid & ~full;

   assign {head_motor, head_dir, head_half} = fifo_mem[rd_ptr];
   assign head_bad  = ({1'b0, head_motor} >= 4'(NUM_MOTORS));
   assign head_mask = NUM_MOTORS'(1) << head_motor;

   // Only the selected driver's done counts; others are masked off.
   assign done_sel = |(bus.done & cur_mask);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_move  = 1'b0;
      complete   = 1'b0;
      err_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_bad) begin
                  err_set = 1'b1;
               end else begin
                  load_move  = 1'b1;
                  state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_next = S_ARM;
         // The driver clears its done on the edge ending ISSUE, so ARM skips one sample.
         S_ARM:   state_next = S_WAIT;
         S_WAIT: begin
            if (done_sel) begin
               complete   = 1'b1;
               state_next = S_GAP;
            end else if (timer == TIMEOUT_LAST) begin
               err_set    = 1'b1;
               state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {bus.move_motor, bus.move_dir, bus.move_half};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_mask     <= '0;
         steps_q      <= '0;
         dir_q        <= '0;
         error_q      <= 1'b0;
         moves_done_q <= '0;
         timer        <= '0;
         gap_cnt      <= '0;
      end else begin
         if (load_move) begin
            cur_mask <= head_mask;
            steps_q  <= head_half ? STEPS_HALF : STEPS_QUARTER;
            dir_q    <= (dir_q & ~head_mask) | (head_dir ? head_mask : '0);
         end
         if (err_set)              error_q <= 1'b1;
         else if (bus.clear_error) error_q <= 1'b0;
         if (complete) moves_done_q <= moves_done_q + 8'd1;
         if (state == S_ARM)       timer <= '0;
         else if (state == S_WAIT) timer <= timer + 1'b1;
         // Reloaded every WAIT cycle so GAP always starts from a full count.
         if (state == S_WAIT)                     gap_cnt <= GAP_LOAD;
         else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end
   end

   assign bus.move_ready = ~full;
   assign bus.start      = (state == S_ISSUE) ? cur_mask : '0;
   assign bus.steps      = steps_q;
   assign bus.dir        = dir_q;
   assign bus.busy       = (state != S_IDLE) | ~empty;
   assign bus.error      = error_q;
   assign bus.moves_done = moves_done_q;
   assign fsm_state      = state;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: one instance with a long timeout for the move
// flow, a second with a 16-cycle timeout for the timeout scenario.
module tb_move_sequencer;

   localparam int GAP_A = 30;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd3, ST_GAP = 3'd4;

   typedef struct {
      logic [2:0] motor;
      logic       d;
      logic       half;
      logic [5:0] exp_start;
      logic [7:0] exp_steps;
      logic [5:0] exp_dir;
   } vec_t;

   logic       clock;
   logic       reset_n;
   logic [2:0] fsm_a, fsm_b;
   int         total = 0;
   int         bad   = 0;

   logic [5:0] log_start[$];
   logic [7:0] log_steps[$];
   logic [5:0] log_dir[$];

   move_sequencer_if #(.NUM_MOTORS(6)) a_if ();
   move_sequencer_if #(.NUM_MOTORS(6)) b_if ();

   move_sequencer #(.NUM_MOTORS(6), .GAP_CYCLES(GAP_A)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(a_if), .fsm_state(fsm_a)
   );

   move_sequencer #(.NUM_MOTORS(6), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(b_if), .fsm_state(fsm_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (a_if.start != '0) begin
         log_start.push_back(a_if.start);
         log_steps.push_back(a_if.steps);
         log_dir.push_back(a_if.dir);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [2:0] m, input logic d, input logic h);
      a_if.move_valid = 1'b1;
      a_if.move_motor = m;
      a_if.move_dir   = d;
      a_if.move_half  = h;
      tick;
      a_if.move_valid = 1'b0;
   endtask

   task automatic push_b(input logic [2:0] m, input logic d, input logic h);
      b_if.move_valid = 1'b1;
      b_if.move_motor = m;
      b_if.move_dir   = d;
      b_if.move_half  = h;
      tick;
      b_if.move_valid = 1'b0;
   endtask

   task automatic finish_a(input int idx);
      int n;
      a_if.done[idx] = 1'b1;
      n = 0;
      while (fsm_a != ST_GAP && n < 100) begin tick; n++; end
      chk("finish_gap", fsm_a, ST_GAP);
      a_if.done[idx] = 1'b0;
      n = 0;
      while (fsm_a != ST_IDLE && n < GAP_A + 10) begin tick; n++; end
      chk("finish_idle", fsm_a, ST_IDLE);
   endtask

   vec_t vecs[5];

   initial begin
      int n, base;

      vecs[0] = '{3'd1, 1'b1, 1'b0, 6'b000010, 8'd50,  6'b000111};
      vecs[1] = '{3'd3, 1'b1, 1'b1, 6'b001000, 8'd100, 6'b001111};
      vecs[2] = '{3'd2, 1'b0, 1'b0, 6'b000100, 8'd50,  6'b001011};
      vecs[3] = '{3'd5, 1'b1, 1'b1, 6'b100000, 8'd100, 6'b101011};
      vecs[4] = '{3'd0, 1'b0, 1'b1, 6'b000001, 8'd100, 6'b101010};

      reset_n = 1'b0;
      a_if.move_valid = 1'b0; a_if.move_motor = '0; a_if.move_dir = 1'b0;
      a_if.move_half = 1'b0; a_if.clear_error = 1'b0; a_if.done = '0;
      b_if.move_valid = 1'b0; b_if.move_motor = '0; b_if.move_dir = 1'b0;
      b_if.move_half = 1'b0; b_if.clear_error = 1'b0; b_if.done = '0;
      repeat (3) tick;

      chk("rst_start", a_if.start, 0);
      chk("rst_steps", a_if.steps, 0);
      chk("rst_dir", a_if.dir, 0);
      chk("rst_error", a_if.error, 0);
      chk("rst_moves", a_if.moves_done, 0);
      chk("rst_busy", a_if.busy, 0);
      chk("rst_ready", a_if.move_ready, 1);
      chk("rst_fsm", fsm_a, ST_IDLE);
      reset_n = 1'b1;
      tick;

      // Quarter move into an idle block
      push_a(3'd2, 1'b1, 1'b0);
      chk("q_start_early", a_if.start, 0);
      chk("q_busy", a_if.busy, 1);
      tick;
      chk("q_start", a_if.start, 6'b000100);
      chk("q_steps", a_if.steps, 50);
      chk("q_dir", a_if.dir, 6'b000100);
      tick;
      chk("q_start_single", a_if.start, 0);
      repeat (58) tick;
      chk("q_moves_before", a_if.moves_done, 0);
      chk("q_fsm_wait", fsm_a, ST_WAIT);
      a_if.done[2] = 1'b1;
      tick;
      chk("q_moves_after", a_if.moves_done, 1);
      chk("q_fsm_gap", fsm_a, ST_GAP);
      a_if.done[2] = 1'b0;

      // Next move queued during the gap; start follows the done edge by GAP+1 edges
      push_a(3'd0, 1'b1, 1'b1);
      n = 1;
      while (a_if.start == '0 && n < GAP_A + 20) begin tick; n++; end
      chk("gap_latency", n, GAP_A + 1);
      chk("h_start", a_if.start, 6'b000001);
      chk("h_steps", a_if.steps, 100);
      chk("h_dir", a_if.dir, 6'b000101);
      tick;
      finish_a(0);
      chk("h_moves", a_if.moves_done, 2);

      // Five moves back-to-back against a four-deep queue
      base = log_start.size();
      for (int i = 0; i < 5; i++) begin
         chk("fill_ready", a_if.move_ready, 1);
         push_a(vecs[i].motor, vecs[i].d, vecs[i].half);
      end
      chk("full_ready", a_if.move_ready, 0);
      a_if.move_valid = 1'b1; a_if.move_motor = 3'd4;
      a_if.move_dir = 1'b1; a_if.move_half = 1'b0;
      repeat (3) tick;
      a_if.move_valid = 1'b0;
      chk("full_hold", a_if.move_ready, 0);
      for (int i = 0; i < 5; i++) begin
         n = 0;
         while (log_start.size() <= base + i && n < GAP_A + 50) begin tick; n++; end
         if (log_start.size() <= base + i) begin
            total++; bad++;
            $display("FAIL tbl_issue: move %0d not issued within %0d cycles", i, n);
         end else begin
            chk("tbl_start", log_start[base+i], vecs[i].exp_start);
            chk("tbl_steps", log_steps[base+i], vecs[i].exp_steps);
            chk("tbl_dir", log_dir[base+i], vecs[i].exp_dir);
         end
         finish_a(vecs[i].motor);
      end
      chk("tbl_moves", a_if.moves_done, 7);
      repeat (10) tick;
      chk("tbl_busy", a_if.busy, 0);
      chk("tbl_count", log_start.size() - base, 5);

      // Stale done held through ISSUE/ARM must not complete the move
      a_if.done[4] = 1'b1;
      push_a(3'd4, 1'b1, 1'b0);
      tick;
      chk("st_start", a_if.start, 6'b010000);
      tick;
      tick;
      chk("st_arm_ignored", fsm_a, ST_WAIT);
      a_if.done[4] = 1'b0;
      repeat (20) tick;
      chk("st_still_wait", fsm_a, ST_WAIT);
      chk("st_moves_before", a_if.moves_done, 7);
      a_if.done[4] = 1'b1;
      tick;
      chk("st_moves_after", a_if.moves_done, 8);
      a_if.done[4] = 1'b0;
      n = 0;
      while (fsm_a != ST_IDLE && n < GAP_A + 10) begin tick; n++; end

      // Invalid motor index
      base = log_start.size();
      push_a(3'd7, 1'b1, 1'b1);
      tick;
      chk("inv_error", a_if.error, 1);
      chk("inv_fsm", fsm_a, ST_IDLE);
      chk("inv_steps", a_if.steps, 50);
      chk("inv_dir", a_if.dir, 6'b111010);
      chk("inv_busy", a_if.busy, 0);
      chk("inv_nostart", log_start.size() - base, 0);
      push_a(3'd1, 1'b0, 1'b0);
      tick;
      chk("inv_next_start", a_if.start, 6'b000010);
      chk("inv_next_dir", a_if.dir, 6'b111000);
      chk("inv_sticky", a_if.error, 1);
      tick;
      finish_a(1);
      chk("inv_moves", a_if.moves_done, 9);
      a_if.clear_error = 1'b1;
      tick;
      a_if.clear_error = 1'b0;
      chk("clr_error", a_if.error, 0);
      push_a(3'd6, 1'b0, 1'b0);
      a_if.clear_error = 1'b1;
      tick;
      a_if.clear_error = 1'b0;
      chk("err_wins", a_if.error, 1);
      a_if.clear_error = 1'b1;
      tick;
      a_if.clear_error = 1'b0;
      chk("clr_error2", a_if.error, 0);

      // Timeout on the 16-cycle instance, then the queued move still runs
      push_b(3'd0, 1'b1, 1'b0);
      push_b(3'd1, 1'b1, 1'b1);
      chk("to_start", b_if.start, 6'b000001);
      tick;
      tick;
      repeat (15) tick;
      chk("to_not_yet", b_if.error, 0);
      chk("to_fsm_wait", fsm_b, ST_WAIT);
      tick;
      chk("to_error", b_if.error, 1);
      chk("to_fsm_gap", fsm_b, ST_GAP);
      chk("to_moves", b_if.moves_done, 0);
      n = 0;
      while (b_if.start == '0 && n < 30) begin tick; n++; end
      chk("to_next_start", b_if.start, 6'b000010);
      chk("to_next_steps", b_if.steps, 100);
      chk("to_next_dir", b_if.dir, 6'b000011);
      n = 0;
      while (fsm_b != ST_IDLE && n < 40) begin tick; n++; end
      chk("to_final_moves", b_if.moves_done, 0);
      chk("to_final_busy", b_if.busy, 0);

      // Reset while waiting with two moves still queued
      push_a(3'd0, 1'b0, 1'b0);
      push_a(3'd2, 1'b1, 1'b1);
      push_a(3'd3, 1'b1, 1'b0);
      tick;
      chk("mr_fsm_wait", fsm_a, ST_WAIT);
      base = log_start.size();
      reset_n = 1'b0;
      #1;
      chk("mr_start", a_if.start, 0);
      chk("mr_steps", a_if.steps, 0);
      chk("mr_dir", a_if.dir, 0);
      chk("mr_moves", a_if.moves_done, 0);
      chk("mr_busy", a_if.busy, 0);
      chk("mr_ready", a_if.move_ready, 1);
      chk("mr_fsm", fsm_a, ST_IDLE);
      chk("mr_b_error", b_if.error, 0);
      a_if.done = 6'b000001;
      repeat (2) tick;
      reset_n = 1'b1;
      repeat (40) tick;
      chk("mr_no_start", log_start.size() - base, 0);
      chk("mr_moves_after", a_if.moves_done, 0);
      chk("mr_busy_after", a_if.busy, 0);
      a_if.done = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
